// File: rtl/sobol_index_decoder.sv
// rtl/sobol_index_decoder.sv - recovers the sequence index of a Gray-code Sobol point
// Solves one Gray-code bit per cycle against latched direction numbers, then converts to binary.
module sobol_index_decoder #(
  parameter int W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_in,
  input  logic [W-1:0]   xi,
  input  logic [W*W-1:0] c,
  output logic [W-1:0]   idx,
  output logic           en_out,
  output logic           err,
  output logic           busy
);

  localparam int KW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   r;
  logic [W-1:0]   g;
  logic [W*W-1:0] cr;
  logic [KW-1:0]  k;
  logic           r_bit;
  logic [W-1:0]   cr_k;
  logic [W-1:0]   bin;

  // Direction number k owns residual bit W-1-k; the triangular structure lets each step decide one Gray bit.
  always_comb begin
    r_bit = 1'b0;
    cr_k  = '0;
    for (int i = 0; i < W; i++) begin
      if (k == KW'(i)) begin
        r_bit = r[W-1-i];
        cr_k  = cr[W*i +: W];
      end
    end
  end

  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(g >> i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_in) state_nxt = STEP;
      STEP:    if (k == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r      <= '0;
      cr     <= '0;
      g      <= '0;
      k      <= '0;
      idx    <= '0;
      en_out <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      en_out <= 1'b0;
      case (state)
        IDLE: begin
          if (en_in) begin
            r    <= xi;
            cr   <= c;
            g    <= '0;
            k    <= KW'(W-1);
            busy <= 1'b1;
          end
        end
        STEP: begin
          for (int i = 0; i < W; i++) begin
            if (k == KW'(i)) g[i] <= r_bit;
          end
          if (r_bit) r <= r ^ cr_k;
          if (k != '0) k <= k - KW'(1);
        end
        DONE: begin
          idx    <= bin;
          err    <= (r != '0);
          en_out <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sobol_index_decoder.sv
// tb/tb_sobol_index_decoder.sv - self-checking bench for sobol_index_decoder
// Expected results are queued at request time and matched when en_out pulses.
module tb_sobol_index_decoder;

  localparam int W = 6;

  typedef struct packed {
    logic [W-1:0] idx;
    logic         err;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           en_in;
  logic [W-1:0]   xi;
  logic [W*W-1:0] c;
  logic [W-1:0]   idx;
  logic           en_out;
  logic           err;
  logic           busy;

  int   checks;
  int   errors;
  int   out_count;
  exp_t sb[$];

  localparam logic [W*W-1:0] C_GOOD = {6'd11, 6'd18, 6'd28, 6'd40, 6'd48, 6'd32};
  localparam logic [W*W-1:0] C_BAD  = {6'd0,  6'd18, 6'd28, 6'd40, 6'd48, 6'd32};

  sobol_index_decoder #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en_in  (en_in),
    .xi     (xi),
    .c      (c),
    .idx    (idx),
    .en_out (en_out),
    .err    (err),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] sobol_point(input int n, input logic [W*W-1:0] cv);
    logic [W-1:0] gc;
    logic [W-1:0] x;
    gc = W'(n ^ (n >> 1));
    x  = '0;
    for (int j = 0; j < W; j++) begin
      if (gc[j]) x = x ^ cv[W*j +: W];
    end
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst && en_out) begin
      exp_t e;
      out_count++;
      chk("result_pending", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("idx", idx, e.idx);
        chk("err", err, e.err);
      end
    end
  end

  // Drives one request as soon as busy is low; returns in the en_out cycle so the next call is back-to-back.
  task automatic decode(input logic [W-1:0] x, input logic [W*W-1:0] cv,
                        input logic [W-1:0] ei, input logic ee, input string tag);
    int n;
    int lat;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_idle_wait"}, busy, 0);
    xi    = x;
    c     = cv;
    en_in = 1'b1;
    sb.push_back('{idx: ei, err: ee});
    @(posedge clk); #1;
    en_in = 1'b0;
    xi    = W'($urandom);
    c     = {$urandom, $urandom};
    lat   = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (en_out) begin
        lat = i;
        break;
      end
      chk({tag, "_busy"}, busy, 1);
    end
    chk({tag, "_latency"}, lat, W + 1);
    chk({tag, "_busy_at_done"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    checks    = 0;
    errors    = 0;
    out_count = 0;
    rst   = 1'b0;
    en_in = 1'b0;
    xi    = '0;
    c     = C_GOOD;

    // 1. reset state and a first decode with pulse-width check
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idx", idx, 0);
    chk("rst_en_out", en_out, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    decode(6'd32, C_GOOD, 6'd1, 1'b0, "t1");
    @(posedge clk); #1;
    chk("t1_pulse_width", en_out, 0);

    // 2. known points back-to-back
    decode(6'd16, C_GOOD, 6'd2, 1'b0, "t2a");
    decode(6'd48, C_GOOD, 6'd3, 1'b0, "t2b");
    decode(6'd24, C_GOOD, 6'd4, 1'b0, "t2c");
    decode(6'd0,  C_GOOD, 6'd0, 1'b0, "t2d");

    // 3. round trip over every index
    for (int n = 0; n < 64; n++) begin
      decode(sobol_point(n, C_GOOD), C_GOOD, W'(n), 1'b0, "t3");
    end

    // 4. en_in held high with changing xi during a decode
    @(posedge clk); #1;
    base  = out_count;
    xi    = 6'd24;
    c     = C_GOOD;
    en_in = 1'b1;
    sb.push_back('{idx: 6'd4, err: 1'b0});
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (en_out) break;
      xi = W'($urandom);
    end
    en_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t4_one_pulse", out_count - base, 1);
    chk("t4_no_accept", busy, 0);
    decode(6'd48, C_GOOD, 6'd3, 1'b0, "t4_next");

    // 5. malformed direction numbers leave a residual
    decode(6'd1, C_BAD, 6'd63, 1'b1, "t5");

    // 6. asynchronous reset mid-decode
    @(posedge clk); #1;
    xi    = 6'd16;
    c     = C_GOOD;
    en_in = 1'b1;
    @(posedge clk); #1;
    en_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    base = out_count;
    rst  = 1'b0;
    #1;
    chk("t6_idx", idx, 0);
    chk("t6_err", err, 0);
    chk("t6_busy", busy, 0);
    chk("t6_en_out", en_out, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("t6_no_en_out", out_count - base, 0);
    decode(6'd48, C_GOOD, 6'd3, 1'b0, "t6_next");

    @(posedge clk); #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
